fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
Round-robin, burst-based write arbiter that shares one synchronous FIFO write port among NUM_REQ producers.
- It sits in front of the team's sync FIFO: it drives the FIFO's write request and data, and reads back its fill count and full flag.
- It grants one producer at a time for up to BURST_LEN beats.
- A burst starts only when the FIFO has room for the whole burst, so a granted producer is never stalled mid-burst by a full FIFO.

Parameters:
NUM_REQ, 4, number of producers (2..8)
DATA_WIDTH, 8, beat width; must match the FIFO data width
ADDR_WIDTH, 4, FIFO address width; FIFO depth = 2**ADDR_WIDTH
BURST_LEN, 4, maximum beats per grant (1..2**ADDR_WIDTH)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
req  input  NUM_REQ  per-producer beat valid; held while the producer has data
req_data  input  NUM_REQ*DATA_WIDTH  producer i data on bits [i*DATA_WIDTH +: DATA_WIDTH]
req_last  input  NUM_REQ  producer i marks the current beat as the final beat of its burst
ack  output  NUM_REQ  one-hot, combinational; beat from producer i accepted this cycle
grant  output  NUM_REQ  one-hot registered current owner; 0 when idle
busy  output  1  high in state BURST
fifo_wr_req  output  1  registered FIFO write strobe
fifo_data  output  DATA_WIDTH  registered FIFO write data
fifo_num  input  ADDR_WIDTH+1  FIFO occupancy count
fifo_wr_full  input  1  FIFO full flag

Behaviour:
- Reset (async, any time): state=IDLE, grant=0, rr_ptr=0, beat_cnt=0, fifo_wr_req=0, fifo_data=0. A beat in flight is dropped. ack is 0 while rst is high.
- Free space: free = 2**ADDR_WIDTH - fifo_num - fifo_wr_req, computed (ADDR_WIDTH+2) bits wide. This accounts for the registered write not yet counted in fifo_num.
- State IDLE:
  - If |req and free >= BURST_LEN, pick the winner: the first set req bit searching from rr_ptr upward, modulo NUM_REQ.
  - On a winner: grant <= onehot(winner), beat_cnt <= 0, go to BURST.
  - No ack is issued in IDLE.
- State BURST (owner o):
  - ack[o] = req[o] & ~fifo_wr_full. All other ack bits are 0.
  - On ack: fifo_wr_req <= 1, fifo_data <= req_data slice o, beat_cnt <= beat_cnt+1. Otherwise fifo_wr_req <= 0.
  - Burst ends when any of these holds:
    - ack and (beat_cnt == BURST_LEN-1 or req_last[o]);
    - req[o] == 0 (owner withdrew; no beat that cycle).
  - On burst end: grant <= 0, rr_ptr <= (o+1) mod NUM_REQ, go to IDLE.
- Latency:
  - Accepted beat appears on fifo_wr_req/fifo_data 1 cycle after ack.
  - Minimum 1 idle cycle between bursts. Peak throughput = BURST_LEN/(BURST_LEN+1).
- Fairness: a producer waits at most NUM_REQ-1 bursts once the FIFO has space.
- fifo_wr_full during BURST is a safety gate only. With the reservation rule and a FIFO that never grows except through this port, it does not assert mid-burst.
- Simultaneous FIFO read and write: handled by the fifo_num value presented; no special case here.
- Owner holds req but FIFO full: ack stays 0 and grant is held until full clears.

Optional Feature:
FIFO_WR_ARB_PRIO0_EN
- Defined: producer 0 is high priority. In IDLE, if req[0]=1 and space is available, producer 0 wins regardless of rr_ptr. rr_ptr is not advanced after a producer-0 burst. Producers 1..NUM_REQ-1 remain round-robin among themselves.
- Undefined: pure round-robin over all producers as described above.

Test Plan:
1. Reset, fifo_num=0, req=4'b0001, req_last on the 3rd beat, data 0xA1,0xA2,0xA3 -> ack[0] on 3 consecutive cycles; fifo_wr_req high 1 cycle later writing A1,A2,A3; grant returns to 0; rr_ptr=1.
2. req=4'b1111 held continuously, fifo_num=0 with the FIFO drained each write, BURST_LEN=4 -> grants in order 0,1,2,3,0; 4 acks each; 1 idle cycle between bursts.
3. fifo_num=13 (free 3 < BURST_LEN=4), req=4'b0010 -> no grant; lower fifo_num to 12 -> grant=4'b0010 the next cycle.
4. Owner 2 granted, drops req after 2 beats -> burst ends immediately; rr_ptr=3; a pending req[3] is granted on the following IDLE cycle.
5. Assert rst mid-burst after beat 2 -> grant, busy, fifo_wr_req, fifo_data all 0 immediately (asynchronous); after release, state is IDLE and rr_ptr=0.
6. With FIFO_WR_ARB_PRIO0_EN defined, req=4'b1110 then req[0] rises during producer 1's burst -> producer 0 is granted next; rr_ptr=2 is retained, so producer 2 follows.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-based arbiter sharing one sync FIFO write port among NUM_REQ producers.
// Optional macro FIFO_WR_ARB_PRIO0_EN makes producer 0 high priority over the round-robin set.
//
// Handshake: req[i] is a beat-valid held by producer i while it has data; ack[i] is the
// combinational accept for that cycle. A beat transfers on a cycle where req[i] & ack[i].
// The producer must keep req_data/req_last stable until ack or until it withdraws req.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          fifo_wr_req,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  input  logic [ADDR_WIDTH:0]           fifo_num,
  input  logic                          fifo_wr_full,
  output logic                          dbg_state,
  output logic [$clog2(NUM_REQ)-1:0]    dbg_rr_ptr
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int SUM_W  = PTR_W + 1;
  localparam int CNT_W  = ADDR_WIDTH + 1;
  localparam int FREE_W = ADDR_WIDTH + 2;

  localparam logic [FREE_W-1:0] DEPTH      = FREE_W'(2 ** ADDR_WIDTH);
  localparam logic [FREE_W-1:0] BURST_NEED = FREE_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(BURST_LEN - 1);
  localparam logic [PTR_W-1:0]  LAST_IDX   = PTR_W'(NUM_REQ - 1);
  localparam logic [SUM_W-1:0]  NUM_REQ_W  = SUM_W'(NUM_REQ);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [NUM_REQ-1:0]    r_grant, w_grant_nxt;
  logic [PTR_W-1:0]      r_owner, w_owner_nxt;
  logic [PTR_W-1:0]      r_rr_ptr, w_rr_ptr_nxt;
  logic [CNT_W-1:0]      r_beat_cnt, w_beat_cnt_nxt;
  logic                  r_wr_req, w_wr_req_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;

  logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];
  logic [FREE_W-1:0]     w_free;
  logic                  w_room;
  logic                  w_found;
  logic [PTR_W-1:0]      w_winner;
  logic [SUM_W-1:0]      w_sum;
  logic [PTR_W-1:0]      w_cand;
  logic                  w_owner_req;
  logic                  w_owner_last;
  logic [DATA_WIDTH-1:0] w_owner_data;
  logic [PTR_W-1:0]      w_owner_inc;
  logic                  w_beat;
  logic                  w_burst_end;
  logic [NUM_REQ-1:0]    w_ack;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign w_slice[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // The registered write still in flight is not yet in fifo_num, so reserve it too.
  assign w_free = DEPTH - FREE_W'(fifo_num) - FREE_W'(r_wr_req);
  assign w_room = (w_free >= BURST_NEED);

  assign w_owner_req  = req[r_owner];
  assign w_owner_last = req_last[r_owner];
  assign w_owner_data = w_slice[r_owner];
  assign w_owner_inc  = (r_owner == LAST_IDX) ? '0 : r_owner + PTR_W'(1);

  // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    w_cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + SUM_W'(i);
      if (w_sum >= NUM_REQ_W) begin
        w_sum = w_sum - NUM_REQ_W;
      end
      w_cand = w_sum[PTR_W-1:0];
      if (!w_found && req[w_cand]) begin
        w_found  = 1'b1;
        w_winner = w_cand;
      end
    end
`ifdef FIFO_WR_ARB_PRIO0_EN
    if (req[0]) begin
      w_found  = 1'b1;
      w_winner = '0;
    end
`endif
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_owner_nxt    = r_owner;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_beat_cnt_nxt = r_beat_cnt;
    w_wr_req_nxt   = 1'b0;
    w_data_nxt     = r_data;
    w_ack          = '0;
    w_beat         = 1'b0;
    w_burst_end    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found && w_room) begin
          w_state_nxt    = S_BURST;
          w_grant_nxt    = NUM_REQ'(1) << w_winner;
          w_owner_nxt    = w_winner;
          w_beat_cnt_nxt = '0;
        end
      end
      S_BURST: begin
        // Full should never be seen here given the reservation; it only gates the accept.
        w_beat = w_owner_req & ~fifo_wr_full;
        if (w_beat) begin
          w_ack          = r_grant;
          w_wr_req_nxt   = 1'b1;
          w_data_nxt     = w_owner_data;
          w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
        end
        w_burst_end = (w_beat && ((r_beat_cnt == LAST_BEAT) || w_owner_last)) || !w_owner_req;
        if (w_burst_end) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
`ifdef FIFO_WR_ARB_PRIO0_EN
          if (r_owner != '0) begin
            w_rr_ptr_nxt = w_owner_inc;
          end
`else
          w_rr_ptr_nxt = w_owner_inc;
`endif
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_wr_req   <= 1'b0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_owner    <= w_owner_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_wr_req   <= w_wr_req_nxt;
      r_data     <= w_data_nxt;
    end
  end

  // Reset forces IDLE asynchronously, which also silences ack while rst is high.
  assign ack         = w_ack;
  assign grant       = r_grant;
  assign busy        = (r_state == S_BURST);
  assign fifo_wr_req = r_wr_req;
  assign fifo_data   = r_data;
  assign dbg_state   = (r_state == S_BURST);
  assign dbg_rr_ptr  = r_rr_ptr;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against a
// transaction-level reference model and an expected-write queue.
module tb_fifo_wr_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int BL    = 4;
  localparam int DEPTH = 16;
  localparam int PW    = 2;
  localparam int TW    = NR * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req, req_last, ack, grant;
  logic [TW-1:0] req_data;
  logic          busy, fifo_wr_req, fifo_wr_full, dbg_state;
  logic [DW-1:0] fifo_data;
  logic [AW:0]   fifo_num;
  logic [PW-1:0] dbg_rr_ptr;

  int n_tests = 0;
  int n_fail  = 0;
  int n_writes;

  // reference model state
  bit            m_busy;
  int            m_owner, m_rr, m_cnt, f_cnt;
  bit            m_wr;
  logic [DW-1:0] m_data;
  logic [NR-1:0] m_ack;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] p_data[NR];

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .grant(grant), .busy(busy), .fifo_wr_req(fifo_wr_req), .fifo_data(fifo_data),
    .fifo_num(fifo_num), .fifo_wr_full(fifo_wr_full), .dbg_state(dbg_state),
    .dbg_rr_ptr(dbg_rr_ptr)
  );

  always #5 clk = ~clk;

  task automatic tb_check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h required %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic pack_data();
    req_data = '0;
    for (int k = 0; k < NR; k++) req_data = req_data | (TW'(p_data[PW'(k)]) << (k * DW));
  endtask

  task automatic drive_fifo();
    fifo_num     = (AW + 1)'(f_cnt);
    fifo_wr_full = (f_cnt == DEPTH);
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_rr = 0; m_cnt = 0; m_wr = 0; m_data = '0; m_ack = '0;
    exp_q.delete();
  endtask

  function automatic int pick_winner();
    int w;
    w = -1;
`ifdef FIFO_WR_ARB_PRIO0_EN
    if (req[0]) return 0;
`endif
    for (int k = 0; k < NR; k++)
      if (w < 0 && req[PW'((m_rr + k) % NR)]) w = (m_rr + k) % NR;
    return w;
  endfunction

  // Check one cycle at the falling edge, advance the model, then let the edge happen.
  task automatic run_cycle(input bit drain);
    int free, win, nf;
    bit fin;
    @(negedge clk);
    m_ack = '0;
    if (m_busy && req[PW'(m_owner)] && f_cnt < DEPTH) m_ack[PW'(m_owner)] = 1'b1;
    tb_check("ack", ack, m_ack);
    tb_check("grant", grant, m_busy ? (32'd1 << m_owner) : 32'd0);
    tb_check("busy", busy, m_busy);
    tb_check("dbg_state", dbg_state, m_busy);
    tb_check("rr_ptr", dbg_rr_ptr, m_rr);
    tb_check("wr_req", fifo_wr_req, m_wr);
    tb_check("wr_data", fifo_data, m_data);
    if (fifo_wr_req) begin
      n_writes++;
      if (exp_q.size() == 0) tb_check("sb_pending", exp_q.size(), 1);
      else tb_check("sb_data", fifo_data, exp_q.pop_front());
    end
    nf = f_cnt + ((m_wr && f_cnt < DEPTH) ? 1 : 0) - ((drain && f_cnt > 0) ? 1 : 0);
    if (!m_busy) begin
      free = DEPTH - f_cnt - (m_wr ? 1 : 0);
      win  = pick_winner();
      if (win >= 0 && free >= BL) begin
        m_busy = 1; m_owner = win; m_cnt = 0;
      end
    end else begin
      fin = 0;
      if (m_ack != 0) begin
        m_data = DW'(req_data >> (m_owner * DW));
        exp_q.push_back(m_data);
        fin = (m_cnt == BL - 1) || req_last[PW'(m_owner)];
        m_cnt++;
      end
      if (!req[PW'(m_owner)]) fin = 1;
      if (fin) begin
        m_busy = 0;
`ifdef FIFO_WR_ARB_PRIO0_EN
        if (m_owner != 0) m_rr = (m_owner + 1) % NR;
`else
        m_rr = (m_owner + 1) % NR;
`endif
      end
    end
    m_wr  = (m_ack != 0);
    f_cnt = nf;
    @(posedge clk);
    #1;
    drive_fifo();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0; req_last = '0;
    for (int k = 0; k < NR; k++) p_data[PW'(k)] = '0;
    pack_data();
    f_cnt = 0;
    drive_fifo();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    tb_check("rst_grant", grant, 0);
    tb_check("rst_busy", busy, 0);
    tb_check("rst_wr_req", fifo_wr_req, 0);
    tb_check("rst_data", fifo_data, 0);
    tb_check("rst_ack", ack, 0);
    tb_check("rst_rr", dbg_rr_ptr, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic random_producers();
    logic [NR-1:0] r_n, l_n;
    bit on;
    for (int i = 0; i < NR; i++) begin
      on = req[PW'(i)];
      if (on && m_ack[PW'(i)]) begin
        p_data[PW'(i)] = DW'($urandom);
        on = ($urandom_range(0, 3) != 0);
      end else if (on) begin
        if ($urandom_range(0, 15) == 0) on = 0;
      end else begin
        on = ($urandom_range(0, 4) < 2);
      end
      r_n[PW'(i)] = on;
      l_n[PW'(i)] = ($urandom_range(0, 3) == 0);
    end
    req = r_n;
    req_last = l_n;
    pack_data();
  endtask

  initial begin
    logic [DW-1:0] beats[3];
    logic [NR-1:0] g_seen[5];
    logic [NR-1:0] g_exp[5];
    logic [NR-1:0] prev_g;
    int bi, g_n, n;

    rst = 1'b1; req = '0; req_last = '0; req_data = '0;
    fifo_num = '0; fifo_wr_full = 1'b0;

    // single producer, three beats ended by req_last
    do_reset();
    beats[0] = 8'hA1; beats[1] = 8'hA2; beats[2] = 8'hA3;
    bi = 0; n_writes = 0;
    req = 4'b0001; p_data[0] = beats[0]; pack_data();
    for (int c = 0; c < 8; c++) begin
      run_cycle(1'b0);
      if (m_ack[0]) begin
        bi++;
        if (bi < 3) begin
          p_data[0] = beats[bi]; pack_data(); req_last[0] = (bi == 2);
        end else begin
          req = '0; req_last = '0;
        end
      end
    end
    tb_check("t1_writes", n_writes, 3);
    tb_check("t1_rr", dbg_rr_ptr, 1);
    tb_check("t1_grant", grant, 0);

    // all producers requesting with the FIFO drained every cycle
    do_reset();
    req = 4'b1111; g_n = 0; prev_g = '0;
    for (int c = 0; c < 30; c++) begin
      for (int k = 0; k < NR; k++) p_data[PW'(k)] = DW'($urandom);
      pack_data();
      run_cycle(1'b1);
      if (grant != 0 && grant != prev_g && g_n < 5) begin
        g_seen[g_n] = grant; g_n++;
      end
      prev_g = grant;
    end
`ifdef FIFO_WR_ARB_PRIO0_EN
    g_exp = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    g_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    tb_check("t2_bursts", g_n, 5);
    for (int k = 0; k < 5; k++) tb_check("t2_order", g_seen[k], g_exp[k]);
    req = '0;
    repeat (6) run_cycle(1'b1);

    // space reservation threshold
    do_reset();
    f_cnt = 13; drive_fifo();
    req = 4'b0010; p_data[1] = 8'h5C; pack_data();
    repeat (3) run_cycle(1'b0);
    tb_check("t3_no_grant", grant, 0);
    f_cnt = 12; drive_fifo();
    run_cycle(1'b0);
    tb_check("t3_grant", grant, 4'b0010);
    req_last = 4'b0010;
    run_cycle(1'b0);
    req = '0; req_last = '0;
    repeat (3) run_cycle(1'b1);

    // owner withdraws mid-burst
    do_reset();
    req = 4'b1100; p_data[2] = 8'h21; p_data[3] = 8'h31; pack_data();
    n = 0;
    for (int c = 0; c < 6 && n < 2; c++) begin
      run_cycle(1'b0);
      if (m_ack[2]) begin n++; p_data[2] = p_data[2] + 8'd1; pack_data(); end
    end
    req[2] = 1'b0;
    run_cycle(1'b0);
    tb_check("t4_rr", dbg_rr_ptr, 3);
    tb_check("t4_idle", grant, 0);
    run_cycle(1'b0);
    tb_check("t4_grant3", grant, 4'b1000);
    req = '0;
    repeat (4) run_cycle(1'b1);

    // asynchronous reset in the middle of a burst
    do_reset();
    req = 4'b0001; p_data[0] = 8'hB1; pack_data();
    n = 0;
    for (int c = 0; c < 6 && n < 2; c++) begin
      run_cycle(1'b0);
      if (m_ack[0]) begin n++; p_data[0] = 8'hB1 + DW'(n); pack_data(); end
    end
    #2 rst = 1'b1;
    #1;
    tb_check("t5_grant", grant, 0);
    tb_check("t5_busy", busy, 0);
    tb_check("t5_wr_req", fifo_wr_req, 0);
    tb_check("t5_data", fifo_data, 0);
    tb_check("t5_ack", ack, 0);
    model_reset();
    @(posedge clk);
    #1;
    req = '0;
    rst = 1'b0;
    @(negedge clk);
    tb_check("t5_rr", dbg_rr_ptr, 0);
    tb_check("t5_state", dbg_state, 0);
    @(posedge clk);
    #1;
    repeat (2) run_cycle(1'b1);

`ifdef FIFO_WR_ARB_PRIO0_EN
    // producer 0 jumps the round-robin order without moving rr_ptr
    do_reset();
    req = 4'b1110;
    for (int k = 0; k < NR; k++) p_data[PW'(k)] = DW'(8'h60 + k);
    pack_data();
    run_cycle(1'b1);
    tb_check("t6_g1", grant, 4'b0010);
    req[0] = 1'b1; req_last[0] = 1'b1;
    for (int c = 0; c < 10 && grant != 0; c++) run_cycle(1'b1);
    tb_check("t6_rr_after1", dbg_rr_ptr, 2);
    run_cycle(1'b1);
    tb_check("t6_g0", grant, 4'b0001);
    run_cycle(1'b1);
    req[0] = 1'b0; req_last = '0;
    tb_check("t6_rr_kept", dbg_rr_ptr, 2);
    run_cycle(1'b1);
    tb_check("t6_g2", grant, 4'b0100);
    req = '0;
    repeat (6) run_cycle(1'b1);
`endif

    // random traffic with varying drain pressure
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ((c / 500) % 2 == 0) run_cycle($urandom_range(0, 2) == 0);
      else run_cycle($urandom_range(0, 3) != 0);
      random_producers();
    end
    req = '0;
    repeat (8) run_cycle(1'b1);
    tb_check("sb_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
